// File: rtl/riscv_mem_wb.sv
// MEM/WB pipeline register: load alignment/extension, write-back select, register file write port.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module riscv_mem_wb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned INSTRET_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_idx_i,
    input  logic                  mem_rd_we_i,
    input  logic                  mem_load_i,
    input  logic [2:0]            mem_ld_funct3_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic [XLEN-1:0]       mem_alu_res_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] rd_idx_o,
    output logic                  rd_we_o,
    output logic [XLEN-1:0]       rd_val_o,
    output logic                  wb_valid_o,
    output logic [INSTRET_W-1:0]  instret_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic [XLEN-1:0]   load_val;
    logic              legal_load;
    logic [XLEN-1:0]   wb_val;
    logic              wb_we;

    // Load alignment and extension; reserved funct3 kills the write and zeroes the value
    always_comb begin
        load_val   = '0;
        legal_load = 1'b1;
        byte_sel   = mem_rdata_i[{mem_addr_lo_i, 3'b000} +: BYTE_W];
        half_sel   = mem_addr_lo_i[1] ? mem_rdata_i[2*HALF_W-1:HALF_W] : mem_rdata_i[HALF_W-1:0];
        if (mem_load_i) begin
            case (mem_ld_funct3_i)
                3'b000:  load_val = {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
                3'b001:  load_val = {{(XLEN-HALF_W){half_sel[HALF_W-1]}}, half_sel};
                3'b010:  load_val = mem_rdata_i;
                3'b100:  load_val = {{(XLEN-BYTE_W){1'b0}}, byte_sel};
                3'b101:  load_val = {{(XLEN-HALF_W){1'b0}}, half_sel};
                default: legal_load = 1'b0;
            endcase
        end
    end

    assign wb_val = mem_load_i ? load_val : mem_alu_res_i;
    assign wb_we  = mem_valid_i & mem_rd_we_i & (mem_rd_idx_i != '0) & legal_load;

    // WB slot: flush kills, stall holds, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            rd_we_o    <= 1'b0;
            rd_idx_o   <= '0;
            rd_val_o   <= '0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
            rd_we_o    <= 1'b0;
        end else if (!stall_i) begin
            wb_valid_o <= mem_valid_i;
            rd_we_o    <= wb_we;
            rd_idx_o   <= mem_rd_idx_i;
            rd_val_o   <= wb_val;
        end
    end

`ifdef RETIRE_CNT_EN
    // Counts instructions entering WB; wraps naturally at full width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_o <= '0;
        end else if (mem_valid_i && !stall_i && !flush_i) begin
            instret_o <= instret_o + INSTRET_W'(1);
        end
    end
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_wb.sv
// Directed self-checking bench for riscv_mem_wb with hand-computed expected values.
module tb_riscv_mem_wb;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
`ifdef RETIRE_CNT_EN
    localparam int unsigned INSTRET_W  = 4;
`else
    localparam int unsigned INSTRET_W  = 64;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mem_valid_i;
    logic [REG_ADDR_W-1:0] mem_rd_idx_i;
    logic                  mem_rd_we_i;
    logic                  mem_load_i;
    logic [2:0]            mem_ld_funct3_i;
    logic [1:0]            mem_addr_lo_i;
    logic [XLEN-1:0]       mem_alu_res_i;
    logic [XLEN-1:0]       mem_rdata_i;
    logic                  stall_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] rd_idx_o;
    logic                  rd_we_o;
    logic [XLEN-1:0]       rd_val_o;
    logic                  wb_valid_o;
    logic [INSTRET_W-1:0]  instret_o;

    int n_cmp = 0;
    int n_err = 0;

    riscv_mem_wb #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .INSTRET_W(INSTRET_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_i     (mem_valid_i),
        .mem_rd_idx_i    (mem_rd_idx_i),
        .mem_rd_we_i     (mem_rd_we_i),
        .mem_load_i      (mem_load_i),
        .mem_ld_funct3_i (mem_ld_funct3_i),
        .mem_addr_lo_i   (mem_addr_lo_i),
        .mem_alu_res_i   (mem_alu_res_i),
        .mem_rdata_i     (mem_rdata_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .rd_idx_o        (rd_idx_o),
        .rd_we_o         (rd_we_o),
        .rd_val_o        (rd_val_o),
        .wb_valid_o      (wb_valid_o),
        .instret_o       (instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic we,
                          input logic [REG_ADDR_W-1:0] idx, input logic [XLEN-1:0] val);
        chk({tag, ".valid"}, 64'(wb_valid_o), 64'(v));
        chk({tag, ".we"},    64'(rd_we_o),    64'(we));
        chk({tag, ".idx"},   64'(rd_idx_o),   64'(idx));
        chk({tag, ".val"},   64'(rd_val_o),   64'(val));
    endtask

    task automatic load(input logic [2:0] f3, input logic [1:0] off);
        mem_valid_i = 1'b1; mem_rd_we_i = 1'b1; mem_rd_idx_i = 5'd7; mem_load_i = 1'b1;
        mem_ld_funct3_i = f3; mem_addr_lo_i = off;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_i = 1'b0; mem_rd_idx_i = '0; mem_rd_we_i = 1'b0; mem_load_i = 1'b0;
        mem_ld_funct3_i = '0; mem_addr_lo_i = '0; mem_alu_res_i = '0; mem_rdata_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;
        #1;
        chk_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        chk("reset.instret", 64'(instret_o), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // ALU write-back
        mem_valid_i = 1'b1; mem_rd_we_i = 1'b1; mem_rd_idx_i = 5'd5; mem_alu_res_i = 32'h1234_5678;
        tick();
        chk_wb("alu", 1'b1, 1'b1, 5'd5, 32'h1234_5678);

        // Loads from rdata 0x80FF7F01 (bytes: off0=01 off1=7F off2=FF off3=80)
        mem_rdata_i = 32'h80FF_7F01; mem_alu_res_i = 32'h0BAD_0BAD;
        load(3'b000, 2'd3); chk_wb("lb_off3",  1'b1, 1'b1, 5'd7, 32'hFFFF_FF80);
        load(3'b100, 2'd2); chk_wb("lbu_off2", 1'b1, 1'b1, 5'd7, 32'h0000_00FF);
        load(3'b100, 2'd1); chk_wb("lbu_off1", 1'b1, 1'b1, 5'd7, 32'h0000_007F);
        load(3'b001, 2'd2); chk_wb("lh_off2",  1'b1, 1'b1, 5'd7, 32'hFFFF_80FF);
        load(3'b101, 2'd0); chk_wb("lhu_off0", 1'b1, 1'b1, 5'd7, 32'h0000_7F01);
        load(3'b010, 2'd2); chk_wb("lw_off2",  1'b1, 1'b1, 5'd7, 32'h80FF_7F01);
        load(3'b011, 2'd0); chk_wb("rsv_011",  1'b1, 1'b0, 5'd7, 32'h0);
        load(3'b111, 2'd1); chk_wb("rsv_111",  1'b1, 1'b0, 5'd7, 32'h0);

        // x0 guard
        mem_load_i = 1'b0; mem_rd_idx_i = 5'd0; mem_alu_res_i = 32'h0000_DEAD;
        tick();
        chk_wb("x0", 1'b1, 1'b0, 5'd0, 32'h0000_DEAD);

        // Stall holds for 3 cycles while inputs change, then flush wins over stall
        mem_rd_idx_i = 5'd9; mem_alu_res_i = 32'hAAAA_5555;
        tick();
        chk_wb("pre_stall", 1'b1, 1'b1, 5'd9, 32'hAAAA_5555);
        stall_i = 1'b1; mem_rd_idx_i = 5'd3; mem_alu_res_i = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_wb($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd9, 32'hAAAA_5555);
        end
        flush_i = 1'b1;
        tick();
        chk("stflush.valid", 64'(wb_valid_o), 64'd0);
        chk("stflush.we",    64'(rd_we_o),    64'd0);
        stall_i = 1'b0; flush_i = 1'b0;

        // Invalid instruction never writes
        mem_valid_i = 1'b0; mem_rd_idx_i = 5'd4;
        tick();
        chk("invalid.valid", 64'(wb_valid_o), 64'd0);
        chk("invalid.we",    64'(rd_we_o),    64'd0);

        // Mid-run async reset with a live slot
        mem_valid_i = 1'b1;
        tick();
        chk("pre_rst.we", 64'(rd_we_o), 64'd1);
        rst = 1'b1;
        #1;
        chk_wb("midrst", 1'b0, 1'b0, 5'd0, 32'h0);
        chk("midrst.instret", 64'(instret_o), 64'd0);
        tick();
        chk("rst_held.we", 64'(rd_we_o), 64'd0);
        rst = 1'b0; mem_valid_i = 1'b0;
        tick();
        chk("post_rst.we", 64'(rd_we_o), 64'd0);
        mem_valid_i = 1'b1; mem_rd_idx_i = 5'd12; mem_alu_res_i = 32'hCAFE_F00D;
        tick();
        chk_wb("recapture", 1'b1, 1'b1, 5'd12, 32'hCAFE_F00D);

        // Retire counting: reset, then 10 entering, 2 flushed, 3 stalled
        rst = 1'b1; #1; rst = 1'b0;
        mem_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1;
        tick(); tick();
        flush_i = 1'b0; stall_i = 1'b1;
        tick(); tick(); tick();
        stall_i = 1'b0; mem_valid_i = 1'b0;
        tick();
`ifdef RETIRE_CNT_EN
        chk("instret10", 64'(instret_o), 64'd10);
        mem_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("instret15", 64'(instret_o), 64'd15);
        tick();
        chk("instret_wrap", 64'(instret_o), 64'd0);
        mem_valid_i = 1'b0;
`else
        chk("instret_tied", 64'(instret_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
